// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - RATE codes, NCBPS constants, state encoding and RATE decode for the coded-bit buffer sequencer
package enc_pkg;

  localparam logic [3:0] RATE_6  = 4'b1101;
  localparam logic [3:0] RATE_9  = 4'b1111;
  localparam logic [3:0] RATE_12 = 4'b0101;
  localparam logic [3:0] RATE_18 = 4'b0111;
  localparam logic [3:0] RATE_24 = 4'b1001;
  localparam logic [3:0] RATE_36 = 4'b1011;
  localparam logic [3:0] RATE_48 = 4'b0001;
  localparam logic [3:0] RATE_54 = 4'b0011;

  localparam logic [8:0] NCBPS_BPSK  = 9'd48;
  localparam logic [8:0] NCBPS_QPSK  = 9'd96;
  localparam logic [8:0] NCBPS_QAM16 = 9'd192;
  localparam logic [8:0] NCBPS_QAM64 = 9'd288;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_BURST,
    ST_FLUSH,
    ST_DONE
  } state_t;

  // Returns {valid, ncbps}; unknown codes decode to all zeros.
  function automatic logic [9:0] rate_to_ncbps(input logic [3:0] rate);
    logic [9:0] res;
    case (rate)
      RATE_6,  RATE_9:  res = {1'b1, NCBPS_BPSK};
      RATE_12, RATE_18: res = {1'b1, NCBPS_QPSK};
      RATE_24, RATE_36: res = {1'b1, NCBPS_QAM16};
      RATE_48, RATE_54: res = {1'b1, NCBPS_QAM64};
      default:          res = 10'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/enc_buf_ctrl_if.sv
// rtl/enc_buf_ctrl_if.sv - encoder beat, buffer strobe and interleaver burst signals of the buffer sequencer
interface enc_buf_ctrl_if;

  logic       enc_valid;
  logic [1:0] enc_nbits;
  logic       enc_last;
  logic       enc_ready;
  logic       buf_clr;
  logic       buf_we;
  logic       buf_two;
  logic       buf_re;
  logic       out_ready;
  logic       sym_start;
  logic       sym_last;
  logic       pad_valid;

  // master: the sequencer, which owns the buffer strobes
  modport master (
    input  enc_valid, enc_nbits, enc_last, out_ready,
    output enc_ready, buf_clr, buf_we, buf_two, buf_re, sym_start, sym_last, pad_valid
  );

  modport slave (
    output enc_valid, enc_nbits, enc_last, out_ready,
    input  enc_ready, buf_clr, buf_we, buf_two, buf_re, sym_start, sym_last, pad_valid
  );

endinterface

// File: rtl/enc_rate_lut.sv
// rtl/enc_rate_lut.sv - registered RATE to NCBPS decode, captured once per accepted packet start
module enc_rate_lut
  import enc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] rate,
  output logic [8:0] ncbps,
  output logic       valid
);

  logic [9:0] dec;

  assign dec = rate_to_ncbps(rate);

  always_ff @(posedge clk) begin
    if (reset) begin
      ncbps <= '0;
      valid <= 1'b0;
    end else if (load) begin
      ncbps <= dec[8:0];
      valid <= dec[9];
    end
  end

endmodule

// File: rtl/enc_buf_ctrl.sv
// rtl/enc_buf_ctrl.sv - coded-bit buffer sequencer: fills, bursts NCBPS bits per symbol, flushes the tail.
// Define ENC_BUF_PAD_EN to pad the final short symbol with zero-bit cycles up to full NCBPS length.
module enc_buf_ctrl
  import enc_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int OCC_W = 13
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [3:0]     rate,
  enc_buf_ctrl_if.master bus,
  output logic           busy,
  output logic           done,
  output logic           err_rate
);

  state_t           state, state_nxt;
  logic [OCC_W-1:0] occ, occ_nxt, wr_bits, ncbps_w;
  logic [8:0]       cnt, cnt_nxt, ncbps;
  logic             ncbps_vld;
  logic             last_seen, last_seen_nxt;
  logic [9:0]       rate_dec;
  logic             start_ok, beat, wr, rd;

  assign rate_dec = rate_to_ncbps(rate);
  assign start_ok = (state == ST_IDLE) && start && rate_dec[9];

  enc_rate_lut u_rate_lut (
    .clk   (clk),
    .reset (reset),
    .load  (start_ok),
    .rate  (rate),
    .ncbps (ncbps),
    .valid (ncbps_vld)
  );

  assign ncbps_w = OCC_W'(ncbps);

  // Two free slots are required so a 2-bit beat can never overflow the buffer.
  assign bus.enc_ready = ((state == ST_FILL) || (state == ST_BURST)) &&
                         (occ <= OCC_W'(DEPTH - 2)) && !last_seen && ncbps_vld;

  assign beat        = bus.enc_valid && bus.enc_ready;
  assign wr          = beat && ((bus.enc_nbits == 2'd1) || (bus.enc_nbits == 2'd2));
  assign bus.buf_we  = wr;
  assign bus.buf_two = wr && (bus.enc_nbits == 2'd2);
  assign wr_bits     = !wr ? '0 : ((bus.enc_nbits == 2'd2) ? OCC_W'(2) : OCC_W'(1));

  assign rd         = (state == ST_BURST) || ((state == ST_FLUSH) && (occ != '0));
  assign bus.buf_re = rd;

  assign occ_nxt       = start_ok ? '0 : (occ + wr_bits - OCC_W'(rd));
  assign last_seen_nxt = start_ok ? 1'b0 : (last_seen || (beat && bus.enc_last));
  assign busy          = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      occ       <= '0;
      cnt       <= '0;
      last_seen <= 1'b0;
    end else begin
      state     <= state_nxt;
      occ       <= occ_nxt;
      cnt       <= cnt_nxt;
      last_seen <= last_seen_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    bus.buf_clr   = 1'b0;
    bus.sym_start = 1'b0;
    bus.sym_last  = 1'b0;
    bus.pad_valid = 1'b0;
    done          = 1'b0;
    err_rate      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          if (rate_dec[9]) begin
            bus.buf_clr = 1'b1;
            cnt_nxt     = '0;
            state_nxt   = ST_FILL;
          end else begin
            err_rate = 1'b1;
          end
        end
      end

      ST_FILL: begin
        if ((occ >= ncbps_w) && bus.out_ready) begin
          cnt_nxt   = '0;
          state_nxt = ST_BURST;
        end else if (last_seen && (occ == '0)) begin
          state_nxt = ST_DONE;
        end else if (last_seen && bus.out_ready) begin
          cnt_nxt   = '0;
          state_nxt = ST_FLUSH;
        end
      end

      ST_BURST: begin
        bus.sym_start = (cnt == '0);
        if (cnt == ncbps - 9'd1) begin
          // Decide on post-cycle occupancy so the next burst's bits are already written.
          cnt_nxt = '0;
          if ((occ_nxt >= ncbps_w) && bus.out_ready) begin
            state_nxt = ST_BURST;
          end else if (!last_seen_nxt || (occ_nxt >= ncbps_w)) begin
            state_nxt = ST_FILL;
          end else if (occ_nxt != '0) begin
            state_nxt = ST_FLUSH;
          end else begin
            bus.sym_last = 1'b1;
            state_nxt    = ST_DONE;
          end
        end else begin
          cnt_nxt = cnt + 9'd1;
        end
      end

      ST_FLUSH: begin
        bus.sym_start = (cnt == '0);
        cnt_nxt       = cnt + 9'd1;
`ifdef ENC_BUF_PAD_EN
        bus.pad_valid = (occ == '0);
        if (cnt == ncbps - 9'd1) begin
          bus.sym_last = 1'b1;
          state_nxt    = ST_DONE;
        end
`else
        if (occ == OCC_W'(1)) begin
          bus.sym_last = 1'b1;
          state_nxt    = ST_DONE;
        end
`endif
      end

      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_enc_buf_ctrl.sv
// tb/tb_enc_buf_ctrl.sv - table-driven packet vectors plus fill-stall and mid-burst reset sequences for enc_buf_ctrl
module tb_enc_buf_ctrl;

  localparam int DEPTH = 4096;
`ifdef ENC_BUF_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  localparam int C_RE = 0, C_PAD = 1, C_WE = 2, C_SS = 3, C_SL = 4, C_DONE = 5;
  localparam int C_ERR = 6, C_CLR = 7, C_RUNS = 8, C_VIOL = 9, C_BUSY = 10, NCTR = 11;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] rate;
  logic       busy, done, err_rate;

  enc_buf_ctrl_if bus ();

  enc_buf_ctrl #(.DEPTH(DEPTH), .OCC_W(13)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rate     (rate),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .err_rate (err_rate)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] rate;
    logic [1:0] nbits;
    int         nbeats;
    bit         exp_err;
    int         exp_starts;
    int         exp_lasts;
    int         exp_last_seg;
    int         exp_pads;
  } vec_t;

  int tests = 0;
  int fails = 0;

  int ctr [NCTR];
  int cyc = 0;
  int mocc = 0;
  int seg = 0;
  int last_seg = 0;
  int last_cyc = 0;
  int done_cyc = 0;
  bit re_prev = 1'b0;

  // Observation-side occupancy model and event counters
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      mocc    = 0;
      re_prev = 1'b0;
      seg     = 0;
    end else begin
      if (bus.buf_clr) begin
        mocc = 0;
        ctr[C_CLR]++;
      end
      if (bus.buf_we) begin
        ctr[C_WE] += bus.buf_two ? 2 : 1;
        mocc      += bus.buf_two ? 2 : 1;
        if (!bus.enc_ready) ctr[C_VIOL]++;
      end
      if (bus.buf_re) begin
        ctr[C_RE]++;
        mocc--;
      end
      if (bus.pad_valid) ctr[C_PAD]++;
      if (bus.buf_re && !re_prev) ctr[C_RUNS]++;
      re_prev = bus.buf_re;
      if (mocc < 0 || mocc > DEPTH) ctr[C_VIOL]++;
      if (bus.sym_start) begin
        ctr[C_SS]++;
        seg = 0;
      end
      if (bus.buf_re || bus.pad_valid) seg++;
      if (bus.sym_last) begin
        ctr[C_SL]++;
        last_seg = seg;
        last_cyc = cyc;
      end
      if (done) begin
        ctr[C_DONE]++;
        done_cyc = cyc;
      end
      if (err_rate) ctr[C_ERR]++;
      if (busy) ctr[C_BUSY]++;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int all_outs();
    return int'({bus.enc_ready, bus.buf_clr, bus.buf_we, bus.buf_two, bus.buf_re,
                 bus.sym_start, bus.sym_last, bus.pad_valid, busy, done, err_rate});
  endfunction

  task automatic run_vec(input vec_t v);
    int base [NCTR];
    int sent;
    int n;
    int exp_reads;
    base = ctr;
    start = 1'b1;
    rate  = v.rate;
    @(posedge clk); #1;
    start = 1'b0;
    if (v.exp_err) begin
      repeat (4) begin @(posedge clk); #1; end
      check({v.name, "_err"}, ctr[C_ERR] - base[C_ERR], 1);
      check({v.name, "_clr"}, ctr[C_CLR] - base[C_CLR], 0);
      check({v.name, "_busy"}, ctr[C_BUSY] - base[C_BUSY], 0);
      return;
    end
    sent = 0;
    n    = 0;
    while (sent < v.nbeats && n < 2000) begin
      bus.enc_valid = 1'b1;
      bus.enc_nbits = v.nbits;
      bus.enc_last  = (sent == v.nbeats - 1);
      @(negedge clk);
      if (bus.enc_ready) sent++;
      @(posedge clk); #1;
      n++;
    end
    bus.enc_valid = 1'b0;
    bus.enc_last  = 1'b0;
    check({v.name, "_beats"}, sent, v.nbeats);
    n = 0;
    while (ctr[C_DONE] == base[C_DONE] && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    exp_reads = (v.nbits == 2'd1 || v.nbits == 2'd2) ? v.nbeats * int'(v.nbits) : 0;
    check({v.name, "_clr"}, ctr[C_CLR] - base[C_CLR], 1);
    check({v.name, "_err"}, ctr[C_ERR] - base[C_ERR], 0);
    check({v.name, "_reads"}, ctr[C_RE] - base[C_RE], exp_reads);
    check({v.name, "_pads"}, ctr[C_PAD] - base[C_PAD], v.exp_pads);
    check({v.name, "_sym_start"}, ctr[C_SS] - base[C_SS], v.exp_starts);
    check({v.name, "_sym_last"}, ctr[C_SL] - base[C_SL], v.exp_lasts);
    check({v.name, "_done"}, ctr[C_DONE] - base[C_DONE], 1);
    check({v.name, "_read_runs"}, ctr[C_RUNS] - base[C_RUNS], (exp_reads > 0) ? 1 : 0);
    check({v.name, "_viol"}, ctr[C_VIOL] - base[C_VIOL], 0);
    check({v.name, "_busy_end"}, int'(busy), 0);
    if (v.exp_lasts == 1) begin
      check({v.name, "_last_seg"}, last_seg, v.exp_last_seg);
      check({v.name, "_done_gap"}, done_cyc - last_cyc, 1);
    end
  endtask

  vec_t vecs [9];
  vec_t clean;

  initial begin
    int base [NCTR];
    int n;

    vecs[0] = '{"r6_x2",     4'b1101, 2'd2, 24,  1'b0, 1, 1, 48,  0};
    vecs[1] = '{"r24_x1",    4'b1001, 2'd1, 200, 1'b0, 2, 1, PAD ? 192 : 8, PAD ? 184 : 0};
    vecs[2] = '{"r12_x2",    4'b0101, 2'd2, 60,  1'b0, 2, 1, PAD ? 96 : 24, PAD ? 72 : 0};
    vecs[3] = '{"r9_x1",     4'b1111, 2'd1, 100, 1'b0, 3, 1, PAD ? 48 : 4,  PAD ? 44 : 0};
    vecs[4] = '{"r48_b2b",   4'b0001, 2'd2, 288, 1'b0, 2, 1, 288, 0};
    vecs[5] = '{"r6_last0",  4'b1101, 2'd0, 1,   1'b0, 0, 0, 0,   0};
    vecs[6] = '{"bad_0000",  4'b0000, 2'd0, 0,   1'b1, 0, 0, 0,   0};
    vecs[7] = '{"bad_1010",  4'b1010, 2'd0, 0,   1'b1, 0, 0, 0,   0};
    vecs[8] = '{"r18_x1",    4'b0111, 2'd1, 96,  1'b0, 1, 1, 96,  0};
    clean   = '{"after_rst", 4'b0101, 2'd2, 48,  1'b0, 1, 1, 96,  0};

    for (int i = 0; i < NCTR; i++) ctr[i] = 0;
    reset         = 1'b1;
    start         = 1'b0;
    rate          = 4'b0000;
    bus.enc_valid = 1'b0;
    bus.enc_nbits = 2'd0;
    bus.enc_last  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_outs(), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Interleaver stalled: 1-bit beats until the buffer stops accepting at DEPTH-1
    base = ctr;
    bus.out_ready = 1'b0;
    start = 1'b1;
    rate  = 4'b0001;
    @(posedge clk); #1;
    start = 1'b0;
    bus.enc_valid = 1'b1;
    bus.enc_nbits = 2'd1;
    repeat (4200) begin @(posedge clk); #1; end
    check("stall_writes", ctr[C_WE] - base[C_WE], DEPTH - 1);
    check("stall_ready", int'(bus.enc_ready), 0);
    check("stall_reads", ctr[C_RE] - base[C_RE], 0);
    check("stall_viol", ctr[C_VIOL] - base[C_VIOL], 0);
    reset         = 1'b1;
    bus.enc_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("stall_reset_busy", int'(busy), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Reset lands on the 30th read of a burst, then a clean packet follows
    base = ctr;
    start = 1'b1;
    rate  = 4'b1101;
    @(posedge clk); #1;
    start = 1'b0;
    for (int b = 0; b < 30; b++) begin
      bus.enc_valid = 1'b1;
      bus.enc_nbits = 2'd2;
      @(posedge clk); #1;
    end
    bus.enc_valid = 1'b0;
    n = 0;
    while (ctr[C_RE] - base[C_RE] < 29 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("midrst_reads_before", ctr[C_RE] - base[C_RE], 29);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_outputs", all_outs(), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    run_vec(clean);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/enc_buf_ctrl.md
Name: enc_buf_ctrl

Overview:
- Sequencer for the convolutional-encoder coded-bit buffer.
- Accepts 1 or 2 coded bits per cycle from the encoder/puncturer and drives the buffer's write, read and clear strobes.
- Tracks buffer occupancy and releases coded bits to the interleaver in uninterrupted bursts of NCBPS bits (one OFDM symbol).
- Flushes the final partial symbol at end of packet.

Parameters:
- DEPTH, 4096: buffer capacity in bits; power of two.
- OCC_W, 13: occupancy counter width; equals log2(DEPTH)+1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  packet start pulse; accepted only in IDLE
- rate  in  4  802.11a RATE code; latched on accepted start
- enc_valid  in  1  encoder beat valid
- enc_nbits  in  2  coded bits in this beat: 1 or 2; 0 or 3 means no write
- enc_last  in  1  final encoder beat; qualified by enc_valid && enc_ready
- enc_ready  out  1  controller can accept a beat
- buf_clr  out  1  one-cycle buffer pointer clear
- buf_we  out  1  buffer write strobe
- buf_two  out  1  write 2 bits this cycle (else 1)
- buf_re  out  1  buffer read strobe; read data valid one cycle later
- out_ready  in  1  interleaver can take a symbol burst
- sym_start  out  1  with first buf_re of each burst
- sym_last  out  1  with final read/pad cycle of the packet
- pad_valid  out  1  pad-bit cycle (zero bit); tied 0 without feature
- busy  out  1  high when state != IDLE
- done  out  1  one-cycle pulse at packet completion
- err_rate  out  1  one-cycle pulse when start carries an unknown rate

Behaviour:
- Reset (synchronous, active-high; clock clk): state IDLE, occupancy 0, burst counter 0, all outputs 0. Applies mid-burst too; there is no partial-symbol recovery.
- NCBPS per RATE code:
  - 1101, 1111 → 48
  - 0101, 0111 → 96
  - 1001, 1011 → 192
  - 0001, 0011 → 288
  - any other code → err_rate pulse, state stays IDLE, buf_clr not asserted
- States: IDLE, FILL, BURST, FLUSH, DONE.
- IDLE, start with valid rate: latch ncbps, pulse buf_clr, clear occ, go to FILL next cycle.
- enc_ready = (FILL or BURST) && (DEPTH - occ >= 2) && !last_seen; combinational from registers only.
- Write accept: enc_valid && enc_ready && nbits in {1,2} → buf_we=1, buf_two=(nbits==2), same cycle. enc_last on an accepted beat sets last_seen; with nbits 0 it sets last_seen without writing.
- occ update each cycle: occ + written bits - buf_re. Read and write in the same cycle are legal.
- FILL → BURST when occ >= ncbps && out_ready; first read is the cycle after the transition.
- BURST: buf_re=1 for exactly ncbps consecutive cycles. sym_start on the first. out_ready is ignored mid-burst.
- BURST end:
  - occ >= ncbps && out_ready → back-to-back BURST, no gap
  - else !last_seen → FILL
  - else occ > 0 → FLUSH
  - else → DONE
- FILL with last_seen and 0 < occ < ncbps → FLUSH when out_ready.
- FILL with last_seen and occ == 0 → DONE.
- FLUSH: buf_re for occ cycles; sym_start on first.
- sym_last marks the final cycle of the packet:
  - on the last full BURST if nothing remains
  - otherwise on the last FLUSH cycle (or last pad cycle with the feature)
- DONE: done=1 for one cycle → IDLE.
- start outside IDLE is ignored.
- occ never exceeds DEPTH, guaranteed by enc_ready; an overflow is a bench assertion failure.

Optional Feature:
- Macro ENC_BUF_PAD_EN.
- Defined: FLUSH reads the remaining occ bits, then asserts pad_valid (buf_re=0) for ncbps-occ cycles so the last symbol is full length. sym_last falls on the final pad cycle.
- Undefined: the last burst is short, pad_valid is tied 0, and sym_last falls on the final real read.

Decomposition:
- Shared package enc_pkg holds:
  - RATE code constants
  - state enumeration
  - NCBPS constants (48/96/192/288)
  - function rate_to_ncbps returning {valid, ncbps[8:0]}
- One sub-module: enc_rate_lut, a registered RATE→NCBPS decode with a valid flag, instantiated once.

Test Plan:
- RATE=1101, 24 beats of nbits=2, last on beat 24 → one 48-cycle BURST, sym_start at read 1, sym_last at read 48, done 1 cycle later.
- RATE=1001, 200 one-bit beats, last on beat 200 → one 192-bit BURST, then FLUSH of 8. Without the macro, sym_last on read 8. With ENC_BUF_PAD_EN, 184 pad_valid cycles follow.
- RATE=0001, continuous 2-bit beats with out_ready=1 → back-to-back 288-cycle bursts with no gap; occ stays non-negative and ≤ DEPTH.
- Hold out_ready=0 with continuous input → enc_ready drops at occ=DEPTH-1; no buf_we while it is low.
- start with RATE=0000 → err_rate pulse, busy stays 0, no buf_clr.
- Reset asserted mid-BURST at read 30 → next cycle all outputs 0, state IDLE; a new start at RATE=0101 runs a clean 96-bit burst.
